// File: rtl/cmos_frame_ctrl.sv
// cmos_frame_ctrl: capture sequencer between the pixel packer and the frame-buffer writer.
// Arms on host command, optionally discards start-up frames, then gates whole
// VSYNC-aligned RGB565 frames to the writer with start/done strobes and counters.
//
// Ports:
//   pclk, rst         pixel clock, asynchronous active-high reset
//   cap_en            level, continuous capture while high
//   cap_single        pulse, capture exactly one frame
//   skip_num[3:0]     frames discarded after arming (sampled leaving IDLE)
//   vs_i, de_i        VSYNC (rising edge = frame boundary), pixel valid
//   pdata_i[15:0]     RGB565 pixel
//   de_o, pdata_o     gated pixel stream to writer (one cycle latency)
//   frame_start       pulse, a captured frame begins
//   frame_done        pulse, a captured frame ended
//   busy              high outside IDLE
//   pix_x, line_y     pixels in current line, completed lines in frame
//   frame_cnt         captured frames, wrapping
//   size_err, err_clr sticky geometry error and its clear
//
// Build option: define CMOS_FRAME_CHECK_EN to enable line-length and
// short-frame checking; otherwise size_err is tied low.

module cmos_frame_ctrl #(
   parameter int H_ACT = 1280,
   parameter int V_ACT = 720
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        cap_en,
   input  logic        cap_single,
   input  logic [3:0]  skip_num,
   input  logic        vs_i,
   input  logic        de_i,
   input  logic [15:0] pdata_i,
   output logic        de_o,
   output logic [15:0] pdata_o,
   output logic        frame_start,
   output logic        frame_done,
   output logic        busy,
   output logic [11:0] pix_x,
   output logic [11:0] line_y,
   output logic [15:0] frame_cnt,
   output logic        size_err,
   input  logic        err_clr
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT_VS = 2'd1;
   localparam logic [1:0] SKIP    = 2'd2;
   localparam logic [1:0] CAPTURE = 2'd3;

   localparam logic [11:0] V_LIM = 12'(V_ACT);

   logic [1:0] state;
   logic [3:0] skip_cnt;
   logic       single_pend;
   logic       vs_r;
   logic       de_r;

   logic vs_rise;
   logic de_fall;
   logic armed;
   logic in_cap;
   logic start_now;
   logic short_end;
   logic last_line;
   logic gate;

   always_comb begin
      vs_rise   = vs_i & ~vs_r;
      de_fall   = ~de_i & de_r;
      armed     = cap_en | single_pend;
      in_cap    = (state == CAPTURE);
      // A pixel arriving with the opening vs_rise belongs to the new frame.
      start_now = vs_rise &
                  (((state == WAIT_VS) & armed & (skip_cnt == 4'd0)) |
                   ((state == SKIP) & (skip_cnt == 4'd1)));
      short_end = in_cap & vs_rise;
      last_line = in_cap & ~vs_rise & de_fall & (line_y == V_LIM - 12'd1);
      // A short frame that ends capture must not pass the next frame's pixel.
      gate      = de_i & (start_now | (in_cap & ~(short_end & ~cap_en)));
   end

   assign busy = (state != IDLE);

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         skip_cnt    <= 4'd0;
         single_pend <= 1'b0;
         vs_r        <= 1'b0;
         de_r        <= 1'b0;
         de_o        <= 1'b0;
         pdata_o     <= 16'd0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         pix_x       <= 12'd0;
         line_y      <= 12'd0;
         frame_cnt   <= 16'd0;
      end else begin
         vs_r        <= vs_i;
         de_r        <= de_i;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         de_o        <= gate;
         if (gate)
            pdata_o <= pdata_i;

         unique case (state)
            IDLE: begin
               pix_x  <= 12'd0;
               line_y <= 12'd0;
               if (armed) begin
                  state    <= WAIT_VS;
                  skip_cnt <= skip_num;
               end
            end
            WAIT_VS: begin
               pix_x  <= 12'd0;
               line_y <= 12'd0;
               if (!armed) begin
                  state <= IDLE;
               end else if (vs_rise) begin
                  if (skip_cnt == 4'd0) begin
                     state       <= CAPTURE;
                     frame_start <= 1'b1;
                     pix_x       <= {11'd0, de_i};
                  end else begin
                     state <= SKIP;
                  end
               end
            end
            SKIP: begin
               pix_x  <= 12'd0;
               line_y <= 12'd0;
               if (vs_rise) begin
                  if (skip_cnt == 4'd1) begin
                     state       <= CAPTURE;
                     frame_start <= 1'b1;
                     pix_x       <= {11'd0, de_i};
                     skip_cnt    <= 4'd0;
                  end else begin
                     skip_cnt <= skip_cnt - 4'd1;
                  end
               end
            end
            CAPTURE: begin
               if (vs_rise) begin
                  // Short frame: close it, restart in place if still enabled.
                  frame_done <= 1'b1;
                  frame_cnt  <= frame_cnt + 16'd1;
                  line_y     <= 12'd0;
                  if (cap_en) begin
                     frame_start <= 1'b1;
                     pix_x       <= {11'd0, de_i};
                  end else begin
                     state       <= IDLE;
                     pix_x       <= 12'd0;
                     single_pend <= 1'b0;
                  end
               end else if (de_fall) begin
                  pix_x  <= 12'd0;
                  line_y <= line_y + 12'd1;
                  if (last_line) begin
                     // line_y shows V_ACT for one cycle, then the new state clears it.
                     frame_done <= 1'b1;
                     frame_cnt  <= frame_cnt + 16'd1;
                     if (cap_en) begin
                        state    <= WAIT_VS;
                        skip_cnt <= 4'd0;
                     end else begin
                        state       <= IDLE;
                        single_pend <= 1'b0;
                     end
                  end
               end else if (de_i) begin
                  pix_x <= pix_x + 12'd1;
               end
            end
            default: state <= IDLE;
         endcase

         // A new single request outranks the clear from a finishing frame.
         if (cap_single)
            single_pend <= 1'b1;
      end
   end

`ifdef CMOS_FRAME_CHECK_EN
   localparam logic [11:0] H_LIM = 12'(H_ACT);

   logic line_bad;
   logic err_set;

   always_comb begin
      line_bad = in_cap & ~vs_rise & de_fall & (pix_x != H_LIM);
      err_set  = line_bad | short_end;
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst)
         size_err <= 1'b0;
      else if (err_set)
         size_err <= 1'b1;
      else if (err_clr)
         size_err <= 1'b0;
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign size_err       = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_frame_ctrl.sv
// tb_cmos_frame_ctrl: directed bench for cmos_frame_ctrl with H_ACT=8, V_ACT=4.
// Vector table for cycle-level behaviour, then multi-frame sequences.

module tb_cmos_frame_ctrl;

   localparam bit O = 1'b0;
   localparam bit I = 1'b1;
`ifdef CMOS_FRAME_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        pclk = 1'b0;
   logic        rst = 1'b1;
   logic        cap_en = 1'b0;
   logic        cap_single = 1'b0;
   logic [3:0]  skip_num = 4'd0;
   logic        vs_i = 1'b0;
   logic        de_i = 1'b0;
   logic [15:0] pdata_i = 16'd0;
   logic        err_clr = 1'b0;
   logic        de_o;
   logic [15:0] pdata_o;
   logic        frame_start;
   logic        frame_done;
   logic        busy;
   logic [11:0] pix_x;
   logic [11:0] line_y;
   logic [15:0] frame_cnt;
   logic        size_err;

   cmos_frame_ctrl #(.H_ACT(8), .V_ACT(4)) dut (
      .pclk(pclk), .rst(rst), .cap_en(cap_en), .cap_single(cap_single),
      .skip_num(skip_num), .vs_i(vs_i), .de_i(de_i), .pdata_i(pdata_i),
      .de_o(de_o), .pdata_o(pdata_o), .frame_start(frame_start),
      .frame_done(frame_done), .busy(busy), .pix_x(pix_x), .line_y(line_y),
      .frame_cnt(frame_cnt), .size_err(size_err), .err_clr(err_clr)
   );

   always #5 pclk = ~pclk;

   int n_chk = 0;
   int n_err = 0;
   int n_de = 0;
   int n_fs = 0;
   int n_fd = 0;
   int done_ly = 0;

   always @(negedge pclk) begin
      if (de_o) n_de++;
      if (frame_start) n_fs++;
      if (frame_done) begin
         n_fd++;
         done_ly = int'(line_y);
      end
   end

   typedef struct {
      bit ce, cs, ec, vs, de;
      logic [15:0] pd;
      bit e_de;
      logic [15:0] e_pd;
      bit e_fs, e_fd, e_bz;
      logic [11:0] e_px, e_ly;
      logic [15:0] e_fc;
      bit e_se;
   } vec_t;

   vec_t vt [16];

   function automatic logic [60:0] outs();
      return {de_o, pdata_o, frame_start, frame_done, busy,
              pix_x, line_y, frame_cnt, size_err};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic vs, input logic de, input logic [15:0] pd);
      @(negedge pclk);
      vs_i = vs;
      de_i = de;
      pdata_i = pd;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 16'h0);
   endtask

   task automatic sample();
      @(posedge pclk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge pclk);
      rst = 1'b1;
      cap_en = 1'b0;
      cap_single = 1'b0;
      err_clr = 1'b0;
      vs_i = 1'b0;
      de_i = 1'b0;
      repeat (2) @(negedge pclk);
      rst = 1'b0;
   endtask

   // One frame: vs pulse, nl lines of 8 pixels (7 on bad_line), blanking.
   // exp_fs is the frame_start value required one cycle after the vs rise.
   task automatic frame(input int nl, input int bad_line, input int drop_line,
                        input bit exp_fs, input string nm);
      drive(1'b1, 1'b0, 16'h0);
      sample();
      chk({nm, "_fs"}, 64'(frame_start), 64'(exp_fs));
      drive(1'b1, 1'b0, 16'h0);
      idle(2);
      for (int l = 0; l < nl; l++) begin
         if (l == drop_line) cap_en = 1'b0;
         for (int p = 0; p < ((l == bad_line) ? 7 : 8); p++)
            drive(1'b0, 1'b1, 16'(l * 16 + p + 1));
         idle(2);
      end
      idle(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int s_de, s_fs, s_fd;

      vt[0]  = '{O,I,O,O,O,16'h0000, O,16'h0000,O,O,O,12'd0,12'd0,16'd0,O};
      vt[1]  = '{O,O,O,O,O,16'h0000, O,16'h0000,O,O,I,12'd0,12'd0,16'd0,O};
      vt[2]  = '{O,O,O,I,O,16'h0000, O,16'h0000,I,O,I,12'd0,12'd0,16'd0,O};
      vt[3]  = '{O,O,O,I,O,16'h0000, O,16'h0000,O,O,I,12'd0,12'd0,16'd0,O};
      vt[4]  = '{O,O,O,O,I,16'h1234, I,16'h1234,O,O,I,12'd1,12'd0,16'd0,O};
      vt[5]  = '{O,O,O,O,I,16'hABCD, I,16'hABCD,O,O,I,12'd2,12'd0,16'd0,O};
      vt[6]  = '{O,O,O,O,O,16'h5555, O,16'hABCD,O,O,I,12'd0,12'd1,16'd0,CHK};
      vt[7]  = '{O,O,I,O,O,16'h0000, O,16'hABCD,O,O,I,12'd0,12'd1,16'd0,O};
      vt[8]  = '{O,O,O,I,O,16'h0000, O,16'hABCD,O,I,O,12'd0,12'd0,16'd1,CHK};
      vt[9]  = '{O,O,I,O,O,16'h0000, O,16'hABCD,O,O,O,12'd0,12'd0,16'd1,O};
      vt[10] = '{I,O,O,O,O,16'h0000, O,16'hABCD,O,O,I,12'd0,12'd0,16'd1,O};
      vt[11] = '{I,O,O,I,I,16'h0F0F, I,16'h0F0F,I,O,I,12'd1,12'd0,16'd1,O};
      vt[12] = '{I,O,O,I,O,16'h0000, O,16'h0F0F,O,O,I,12'd0,12'd1,16'd1,CHK};
      vt[13] = '{I,O,I,O,O,16'h0000, O,16'h0F0F,O,O,I,12'd0,12'd1,16'd1,O};
      vt[14] = '{I,O,O,I,O,16'h0000, O,16'h0F0F,I,I,I,12'd0,12'd0,16'd2,CHK};
      vt[15] = '{I,O,O,O,I,16'h0001, I,16'h0001,O,O,I,12'd1,12'd0,16'd2,CHK};

      repeat (2) @(negedge pclk);
      rst = 1'b0;
      sample();
      chk("reset_state", 64'(outs()), 64'd0);

      for (int k = 0; k < 16; k++) begin
         @(negedge pclk);
         cap_en = vt[k].ce;
         cap_single = vt[k].cs;
         err_clr = vt[k].ec;
         vs_i = vt[k].vs;
         de_i = vt[k].de;
         pdata_i = vt[k].pd;
         sample();
         chk($sformatf("vec%0d", k), 64'(outs()),
             64'({vt[k].e_de, vt[k].e_pd, vt[k].e_fs, vt[k].e_fd, vt[k].e_bz,
                  vt[k].e_px, vt[k].e_ly, vt[k].e_fc, vt[k].e_se}));
      end

      // Reset in the middle of a captured line.
      @(negedge pclk);
      cap_single = 1'b0;
      err_clr = 1'b0;
      de_i = 1'b1;
      pdata_i = 16'h0002;
      sample();
      chk("rst_pre_pix", 64'(pix_x), 64'd2);
      s_fd = n_fd;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_outs", 64'(outs()), 64'd0);
      repeat (2) @(negedge pclk);
      cap_en = 1'b0;
      de_i = 1'b0;
      rst = 1'b0;
      idle(3);
      sample();
      chk("rst_no_done", 64'(n_fd - s_fd), 64'd0);
      chk("rst_idle", 64'(busy), 64'd0);

      // Single capture over three clean frames.
      do_reset();
      skip_num = 4'd0;
      s_de = n_de; s_fs = n_fs; s_fd = n_fd;
      @(negedge pclk);
      cap_single = 1'b1;
      @(negedge pclk);
      cap_single = 1'b0;
      frame(4, -1, -1, 1'b1, "single_f1");
      frame(4, -1, -1, 1'b0, "single_f2");
      frame(4, -1, -1, 1'b0, "single_f3");
      idle(3);
      sample();
      chk("single_starts", 64'(n_fs - s_fs), 64'd1);
      chk("single_dones", 64'(n_fd - s_fd), 64'd1);
      chk("single_pixels", 64'(n_de - s_de), 64'd32);
      chk("single_fcnt", 64'(frame_cnt), 64'd1);
      chk("single_idle", 64'(busy), 64'd0);
      chk("single_done_ly", 64'(done_ly), 64'd4);
      chk("single_no_err", 64'(size_err), 64'd0);

      // Skip two frames, capture the third.
      do_reset();
      skip_num = 4'd2;
      @(negedge pclk);
      cap_en = 1'b1;
      idle(2);
      s_de = n_de; s_fs = n_fs; s_fd = n_fd;
      frame(4, -1, -1, 1'b0, "skip_f1");
      frame(4, -1, -1, 1'b0, "skip_f2");
      sample();
      chk("skip_no_pixels", 64'(n_de - s_de), 64'd0);
      chk("skip_no_start", 64'(n_fs - s_fs), 64'd0);
      frame(4, -1, -1, 1'b1, "skip_f3");
      idle(2);
      sample();
      chk("skip_f3_pixels", 64'(n_de - s_de), 64'd32);
      chk("skip_f3_done", 64'(n_fd - s_fd), 64'd1);
      chk("skip_fcnt", 64'(frame_cnt), 64'd1);
      cap_en = 1'b0;
      idle(2);
      sample();
      chk("skip_idle", 64'(busy), 64'd0);

      // Continuous capture, enable dropped during frame 3 line 2.
      do_reset();
      skip_num = 4'd0;
      @(negedge pclk);
      cap_en = 1'b1;
      idle(2);
      s_de = n_de; s_fd = n_fd;
      frame(4, -1, -1, 1'b1, "cont_f1");
      frame(4, -1, -1, 1'b1, "cont_f2");
      frame(4, -1, 1, 1'b1, "cont_f3");
      idle(2);
      sample();
      chk("cont_fcnt", 64'(frame_cnt), 64'd3);
      chk("cont_pixels", 64'(n_de - s_de), 64'd96);
      chk("cont_dones", 64'(n_fd - s_fd), 64'd3);
      chk("cont_idle", 64'(busy), 64'd0);

      // Seven-pixel line inside a captured frame.
      do_reset();
      @(negedge pclk);
      cap_en = 1'b1;
      idle(2);
      s_de = n_de;
      frame(4, 1, -1, 1'b1, "short_line");
      sample();
      chk("line_err_set", 64'(size_err), 64'(CHK));
      chk("line_err_fcnt", 64'(frame_cnt), 64'd1);
      chk("line_err_pixels", 64'(n_de - s_de), 64'd31);
      @(negedge pclk);
      err_clr = 1'b1;
      @(negedge pclk);
      err_clr = 1'b0;
      sample();
      chk("line_err_clr", 64'(size_err), 64'd0);

      // Short frame: vs rise after two lines with capture enabled.
      do_reset();
      @(negedge pclk);
      cap_en = 1'b1;
      idle(2);
      frame(2, -1, -1, 1'b1, "short_frame");
      sample();
      chk("short_pre_ly", 64'(line_y), 64'd2);
      drive(1'b1, 1'b0, 16'h0);
      sample();
      chk("short_done_start",
          64'({frame_done, frame_start, line_y, size_err, frame_cnt, busy}),
          64'({1'b1, 1'b1, 12'd0, CHK, 16'd1, 1'b1}));
      drive(1'b0, 1'b0, 16'h0);
      cap_en = 1'b0;
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/cmos_frame_ctrl.md
# cmos_frame_ctrl

Capture sequencer between the 8-to-16-bit pixel packer and the frame-buffer writer. Arms on host command, optionally discards a programmable number of start-up frames, then gates whole RGB565 frames through to the writer, aligned to VSYNC. Emits frame start/done strobes, position counters and a frame-geometry error flag.

## Interface
Parameters:
- H_ACT, 1280: active pixels per line (16-bit words).
- V_ACT, 720: active lines per frame.

Ports:
- pclk  in  1  pixel clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- cap_en  in  1  level; continuous capture while high.
- cap_single  in  1  one-cycle pulse; request exactly one frame.
- skip_num  in  4  frames to discard after arming; sampled on leaving IDLE.
- vs_i  in  1  VSYNC, active-high; frame boundary is the rising edge.
- de_i  in  1  pixel valid from packer.
- pdata_i  in  16  RGB565 pixel.
- de_o  out  1  gated pixel valid to writer.
- pdata_o  out  16  pixel to writer.
- frame_start  out  1  one-cycle pulse, first frame of capture or new frame begins.
- frame_done  out  1  one-cycle pulse, captured frame ended.
- busy  out  1  high in every state except IDLE.
- pix_x  out  12  pixels received in current line.
- line_y  out  12  completed lines in current frame.
- frame_cnt  out  16  captured frames, wraps 0xFFFF→0.
- size_err  out  1  sticky geometry error.
- err_clr  in  1  pulse; clears size_err.

## Operation
- vs_r registers vs_i; vs_rise = vs_i & ~vs_r. de_r likewise; de_fall = ~de_i & de_r.
- single_pend set by cap_single, cleared when a single-mode frame_done issues.
- States:
  - IDLE: if cap_en or single_pend → WAIT_VS; skip_cnt ← skip_num.
  - WAIT_VS: if neither cap_en nor single_pend → IDLE. On vs_rise: skip_cnt==0 → CAPTURE, frame_start; else → SKIP.
  - SKIP: on vs_rise: skip_cnt==1 → CAPTURE, frame_start; else skip_cnt−1.
  - CAPTURE: de_o follows de_i; pix_x counts de_i cycles, clears at de_fall; line_y increments at de_fall. When line_y reaches V_ACT: frame_done, frame_cnt+1, → WAIT_VS (skip_cnt forced 0) if cap_en, else → IDLE and clear single_pend.
- cap_en falling mid-frame: current frame completes; no truncation.
- vs_rise in CAPTURE before V_ACT lines (short frame): frame_done, frame_cnt+1, size_err set. If cap_en, stay in CAPTURE, counters clear, frame_start issued (same cycle as frame_done); else → IDLE.
- de_fall with pix_x ≠ H_ACT: size_err set; line still counted.
- Lines after V_ACT are not gated (state has left CAPTURE).
- err_clr and a new error in the same cycle: set wins.

## Timing
- Reset: state IDLE, all outputs 0, skip_cnt, single_pend, vs_r and de_r 0.
- de_i/pdata_i in cycle N → de_o/pdata_o in N+1. pdata_o loads only when the gated valid is 1, else holds.
- vs_rise seen in cycle N → state change and frame_start high in N+1.
- Final de_fall in cycle N → frame_done in N+1. The line_y=V_ACT value is visible in N+1, then clears with the state change.
- A pixel in the vs_rise cycle belongs to the new frame.
- Reset asserted mid-frame: immediate abort, no frame_done.

## Configuration
- CMOS_FRAME_CHECK_EN defined: line-length and short-frame checks active, and size_err/err_clr function as above.
- Not defined: check logic removed and size_err tied 0. A short frame still produces frame_done and a restart.

## Test plan
Bench uses H_ACT=8, V_ACT=4.
- Reset mid-CAPTURE → all outputs 0 on the next cycle, busy 0, no frame_done.
- cap_single pulse, skip_num=0, three clean frames → exactly one frame_start/frame_done pair, 32 de_o pulses, frame_cnt=1, returns to IDLE.
- cap_en=1, skip_num=2 → frames 1–2 produce no de_o; frame 3 gated and frame_start one cycle after the third vs_rise.
- cap_en held high for 3 frames, dropped during frame 3 line 2 → frame 3 completes, frame_cnt=3, then IDLE.
- Line of 7 pixels in a captured frame → size_err=1 after that de_fall; err_clr → 0. With the macro undefined, size_err stays 0.
- vs_rise after 2 lines with cap_en=1 → frame_done and frame_start in the same cycle, line_y=0, size_err=1.
